// File: rtl/vme_dpi_pkg.sv
// Shared constants and state encoding for the VME-to-DPI master bridge.
// Opcode and response codes match the DPI memory model and AXI4.
package vme_dpi_pkg;

  localparam logic OPC_RD = 1'b0;
  localparam logic OPC_WR = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_DATA = 2'd1;
  localparam logic [1:0] ST_WR_RESP = 2'd2;
  localparam logic [1:0] ST_RD_DATA = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    WR_DATA = ST_WR_DATA,
    WR_RESP = ST_WR_RESP,
    RD_DATA = ST_RD_DATA
  } state_e;

endpackage

// File: rtl/vme_dpi_master_bridge.sv
// AXI4 burst slave to DPI memory-model initiator, one burst at a time.
// Define VME_DPI_WLAST_CHECK_EN to report w_last misplacement as SLVERR.
module vme_dpi_master_bridge
  import vme_dpi_pkg::*;
#(
  parameter int LEN_BITS  = 8,
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 512
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_BITS-1:0] aw_addr,
  input  logic [LEN_BITS-1:0]  aw_len,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic                 w_last,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [1:0]           b_resp,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_BITS-1:0] ar_addr,
  input  logic [LEN_BITS-1:0]  ar_len,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 r_last,
  output logic                 dpi_req_valid,
  output logic                 dpi_req_opcode,
  output logic [LEN_BITS-1:0]  dpi_req_len,
  output logic [ADDR_BITS-1:0] dpi_req_addr,
  output logic                 dpi_wr_valid,
  output logic [DATA_BITS-1:0] dpi_wr_bits,
  input  logic                 dpi_rd_valid,
  input  logic [DATA_BITS-1:0] dpi_rd_bits,
  output logic                 dpi_rd_ready
);

  state_e              state;
  logic [LEN_BITS-1:0] cnt;
  logic [LEN_BITS-1:0] len_q;

  logic aw_hs;
  logic ar_hs;
  logic w_hs;
  logic r_hs;
  logic beat_last;

  assign aw_ready = (state == IDLE);
  assign ar_ready = (state == IDLE) & ~aw_valid;
  assign w_ready  = (state == WR_DATA);
  assign b_valid  = (state == WR_RESP);

  assign aw_hs = aw_valid & aw_ready;
  assign ar_hs = ar_valid & ar_ready;
  assign w_hs  = w_valid & w_ready;
  assign r_hs  = r_valid & r_ready;

  // Compare before increment so len=255 ends on beat 256.
  assign beat_last = (cnt == len_q);

  assign dpi_wr_valid = w_hs;
  assign dpi_wr_bits  = w_data;

  // Model beats outside a read burst stay in the model.
  assign r_valid      = (state == RD_DATA) & dpi_rd_valid;
  assign r_data       = dpi_rd_bits;
  assign r_last       = (state == RD_DATA) & beat_last;
  assign dpi_rd_ready = (state == RD_DATA) & r_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      len_q          <= '0;
      dpi_req_valid  <= 1'b0;
      dpi_req_opcode <= 1'b0;
      dpi_req_len    <= '0;
      dpi_req_addr   <= '0;
    end else begin
      dpi_req_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (aw_hs) begin
            dpi_req_valid  <= 1'b1;
            dpi_req_opcode <= OPC_WR;
            dpi_req_len    <= aw_len;
            dpi_req_addr   <= aw_addr;
            len_q          <= aw_len;
            cnt            <= '0;
            state          <= WR_DATA;
          end else if (ar_hs) begin
            dpi_req_valid  <= 1'b1;
            dpi_req_opcode <= OPC_RD;
            dpi_req_len    <= ar_len;
            dpi_req_addr   <= ar_addr;
            len_q          <= ar_len;
            cnt            <= '0;
            state          <= RD_DATA;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            cnt <= cnt + LEN_BITS'(1);
            if (beat_last) state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_ready) state <= IDLE;
        end
        RD_DATA: begin
          if (r_hs) begin
            cnt <= cnt + LEN_BITS'(1);
            if (beat_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VME_DPI_WLAST_CHECK_EN
  logic wlast_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      wlast_err <= 1'b0;
    end else if (aw_hs) begin
      wlast_err <= 1'b0;
    end else if (w_hs && (w_last != beat_last)) begin
      wlast_err <= 1'b1;
    end
  end

  assign b_resp = wlast_err ? RESP_SLVERR : RESP_OKAY;
`else
  logic unused_w_last;

  assign unused_w_last = w_last;
  assign b_resp        = RESP_OKAY;
`endif

endmodule

// File: tb/tb_vme_dpi_master_bridge.sv
// Directed bench for vme_dpi_master_bridge with a simple DPI read model.
// Expected b_resp for the w_last test follows VME_DPI_WLAST_CHECK_EN.
module tb_vme_dpi_master_bridge;

  logic         clock = 1'b0;
  logic         reset;
  logic         aw_valid, aw_ready;
  logic [63:0]  aw_addr;
  logic [7:0]   aw_len;
  logic         w_valid, w_ready;
  logic [511:0] w_data;
  logic         w_last;
  logic         b_valid, b_ready;
  logic [1:0]   b_resp;
  logic         ar_valid, ar_ready;
  logic [63:0]  ar_addr;
  logic [7:0]   ar_len;
  logic         r_valid, r_ready;
  logic [511:0] r_data;
  logic         r_last;
  logic         dpi_req_valid, dpi_req_opcode;
  logic [7:0]   dpi_req_len;
  logic [63:0]  dpi_req_addr;
  logic         dpi_wr_valid;
  logic [511:0] dpi_wr_bits;
  logic         dpi_rd_valid;
  logic [511:0] dpi_rd_bits;
  logic         dpi_rd_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vme_dpi_master_bridge dut (
    .clock          (clock),
    .reset          (reset),
    .aw_valid       (aw_valid),
    .aw_ready       (aw_ready),
    .aw_addr        (aw_addr),
    .aw_len         (aw_len),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .w_data         (w_data),
    .w_last         (w_last),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_resp         (b_resp),
    .ar_valid       (ar_valid),
    .ar_ready       (ar_ready),
    .ar_addr        (ar_addr),
    .ar_len         (ar_len),
    .r_valid        (r_valid),
    .r_ready        (r_ready),
    .r_data         (r_data),
    .r_last         (r_last),
    .dpi_req_valid  (dpi_req_valid),
    .dpi_req_opcode (dpi_req_opcode),
    .dpi_req_len    (dpi_req_len),
    .dpi_req_addr   (dpi_req_addr),
    .dpi_wr_valid   (dpi_wr_valid),
    .dpi_wr_bits    (dpi_wr_bits),
    .dpi_rd_valid   (dpi_rd_valid),
    .dpi_rd_bits    (dpi_rd_bits),
    .dpi_rd_ready   (dpi_rd_ready)
  );

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [511:0] beat(input logic [63:0] a,
                                        input int i);
    return {192'(i), 256'(0), a};
  endfunction

  task automatic wr_burst(input logic [63:0] addr,
                          input logic [7:0]  len,
                          input int          lastpos,
                          input logic [1:0]  exp_resp);
    int strobes = 0;
    int derr    = 0;
    int rdy_err = 0;
    int waited  = 0;
    aw_valid = 1'b1;
    aw_addr  = addr;
    aw_len   = len;
    #1;
    chk("wr_aw_ready", aw_ready, 1'b1);
    tick();
    aw_valid = 1'b0;
    chk("wr_req_valid", dpi_req_valid, 1'b1);
    chk("wr_req_opcode", dpi_req_opcode, 1'b1);
    chk("wr_req_len", dpi_req_len, len);
    chk("wr_req_addr", dpi_req_addr, addr);
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1'b1;
      w_data  = beat(addr, i);
      w_last  = (i == lastpos);
      #1;
      if (w_ready !== 1'b1) rdy_err++;
      if (dpi_wr_valid === 1'b1) begin
        strobes++;
        if (dpi_wr_bits !== w_data) derr++;
      end
      if (i == 1) begin
        chk("wr_req_pulse_end", dpi_req_valid, 1'b0);
        chk("wr_req_len_hold", dpi_req_len, len);
      end
      tick();
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    chk("wr_strobes", strobes, int'(len) + 1);
    chk("wr_data_err", derr, 0);
    chk("wr_ready_err", rdy_err, 0);
    chk("wr_ready_after", w_ready, 1'b0);
    while (b_valid !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    chk("wr_b_valid", b_valid, 1'b1);
    chk("wr_b_resp", b_resp, exp_resp);
    tick();
    chk("wr_b_done", b_valid, 1'b0);
    chk("wr_idle", aw_ready, 1'b1);
  endtask

  task automatic rd_burst(input logic [63:0] addr,
                          input logic [7:0]  len,
                          input bit          toggle);
    int idx     = 0;
    int nlast   = 0;
    int lastidx = -1;
    int derr    = 0;
    int mirr    = 0;
    bit took;
    ar_valid = 1'b1;
    ar_addr  = addr;
    ar_len   = len;
    #1;
    chk("rd_ar_ready", ar_ready, 1'b1);
    tick();
    ar_valid = 1'b0;
    chk("rd_req_valid", dpi_req_valid, 1'b1);
    chk("rd_req_opcode", dpi_req_opcode, 1'b0);
    chk("rd_req_len", dpi_req_len, len);
    chk("rd_req_addr", dpi_req_addr, addr);
    for (int c = 0; c < 2000 && idx <= int'(len); c++) begin
      dpi_rd_valid = (c >= 1);
      dpi_rd_bits  = beat(addr, idx);
      r_ready      = !toggle || (c % 2 == 1);
      #1;
      if (dpi_rd_ready !== r_ready) mirr++;
      if (r_valid !== dpi_rd_valid) mirr++;
      if (r_valid && r_last && idx != int'(len)) derr++;
      took = r_valid && r_ready;
      if (took) begin
        if (r_data !== beat(addr, idx)) derr++;
        if (r_last) begin
          nlast++;
          lastidx = idx;
        end
      end
      tick();
      if (took) idx++;
    end
    chk("rd_beats", idx, int'(len) + 1);
    chk("rd_last_count", nlast, 1);
    chk("rd_last_pos", lastidx, int'(len));
    chk("rd_data_err", derr, 0);
    chk("rd_mirror_err", mirr, 0);
    dpi_rd_valid = 1'b1;
    r_ready      = 1'b1;
    #1;
    chk("rd_stray_r_valid", r_valid, 1'b0);
    chk("rd_stray_rd_ready", dpi_rd_ready, 1'b0);
    chk("rd_idle", aw_ready, 1'b1);
    dpi_rd_valid = 1'b0;
    r_ready      = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    aw_valid     = 1'b0;
    aw_addr      = '0;
    aw_len       = '0;
    w_valid      = 1'b0;
    w_data       = '0;
    w_last       = 1'b0;
    b_ready      = 1'b1;
    ar_valid     = 1'b0;
    ar_addr      = '0;
    ar_len       = '0;
    r_ready      = 1'b0;
    dpi_rd_valid = 1'b0;
    dpi_rd_bits  = '0;
    tick();
    tick();
    chk("rst_req_valid", dpi_req_valid, 1'b0);
    chk("rst_req_addr", dpi_req_addr, 64'h0);
    chk("rst_req_len", dpi_req_len, 8'h0);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_b_resp", b_resp, 2'b00);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_aw_ready", aw_ready, 1'b1);
    reset = 1'b0;
    tick();

    wr_burst(64'h1000, 8'd3, 3, 2'b00);
    rd_burst(64'h2000, 8'd1, 1'b1);

    aw_valid = 1'b1;
    aw_addr  = 64'h5000;
    aw_len   = 8'd0;
    ar_valid = 1'b1;
    ar_addr  = 64'h6000;
    ar_len   = 8'd0;
    #1;
    chk("pri_ar_ready", ar_ready, 1'b0);
    chk("pri_aw_ready", aw_ready, 1'b1);
    tick();
    aw_valid = 1'b0;
    chk("pri_opcode_wr", dpi_req_opcode, 1'b1);
    chk("pri_addr_wr", dpi_req_addr, 64'h5000);
    w_valid = 1'b1;
    w_data  = beat(64'h5000, 0);
    w_last  = 1'b1;
    #1;
    chk("pri_ar_ready_wdata", ar_ready, 1'b0);
    tick();
    w_valid = 1'b0;
    w_last  = 1'b0;
    chk("pri_b_valid", b_valid, 1'b1);
    chk("pri_ar_ready_wresp", ar_ready, 1'b0);
    tick();
    chk("pri_ar_ready_idle", ar_ready, 1'b1);
    tick();
    ar_valid = 1'b0;
    chk("pri_opcode_rd", dpi_req_opcode, 1'b0);
    chk("pri_addr_rd", dpi_req_addr, 64'h6000);
    dpi_rd_valid = 1'b1;
    dpi_rd_bits  = beat(64'h6000, 0);
    r_ready      = 1'b1;
    #1;
    chk("pri_r_last", r_last, 1'b1);
    chk("pri_r_data", r_data, beat(64'h6000, 0));
    tick();
    dpi_rd_valid = 1'b0;
    r_ready      = 1'b0;
    chk("pri_rd_done", aw_ready, 1'b1);

    rd_burst(64'h8000, 8'd255, 1'b0);

    aw_valid = 1'b1;
    aw_addr  = 64'h4000;
    aw_len   = 8'd3;
    tick();
    aw_valid = 1'b0;
    w_valid  = 1'b1;
    tick();
    tick();
    w_valid = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_aw_ready", aw_ready, 1'b1);
    chk("mid_rst_w_ready", w_ready, 1'b0);
    chk("mid_rst_b_valid", b_valid, 1'b0);
    chk("mid_rst_req_valid", dpi_req_valid, 1'b0);
    chk("mid_rst_r_valid", r_valid, 1'b0);
    tick();
    chk("mid_rst_no_b", b_valid, 1'b0);

`ifdef VME_DPI_WLAST_CHECK_EN
    wr_burst(64'h7000, 8'd2, 1, 2'b10);
`else
    wr_burst(64'h7000, 8'd2, 1, 2'b00);
`endif
    wr_burst(64'h9000, 8'd0, 0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
